gate_op_scheduler: RTL

- Shares one bitwise two-input logic unit among NREQ requesters.
- The unit provides AND, NAND, OR, NOR, XOR, XNOR, NOT a and NOT b.
- Round-robin arbitration, valid/ready request and response handshakes, and a 3-state sequencer that latches operands, evaluates once and holds the result until it is consumed.
- Sits between client blocks and the gate datapath. Also provides a completed-operation counter for bench and debug visibility.

---
 rtl/gate_op_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gate_op_scheduler.sv
// gate_op_scheduler: round-robin front end that shares one bitwise logic unit
// (AND/NAND/OR/NOR/XOR/XNOR/NOT a/NOT b) among NREQ requesters. Each accepted
// op is latched, evaluated once, and held on the response port until consumed.
module gate_op_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [IDW-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [2:0]       op_q,       op_d;
    logic [WIDTH-1:0] a_q,        a_d;
    logic [WIDTH-1:0] b_q,        b_d;
    logic [IDW-1:0]   id_q,       id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [15:0]      op_count_q, op_count_d;

    logic [NREQ-1:0]  rot_valid;
    logic [NREQ-1:0]  rot_pick;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic [2:0]       grant_op;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] grant_b;

    // The shared bitwise logic unit.
    function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return ~b;
        endcase
    endfunction

    // Round-robin pick: rotate valids so rr_ptr sits at bit 0, take the lowest
    // set bit, rotate the one-hot back, then mux out the winner's fields.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves a variable unassigned would infer a latch.
        rot_valid = NREQ'({req_valid, req_valid} >> rr_ptr_q);
        rot_pick  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) rot_pick = NREQ'(1) << k;
        end
        grant     = NREQ'(({rot_pick, rot_pick} << rr_ptr_q) >> NREQ);
        grant_idx = '0;
        grant_op  = '0;
        grant_a   = '0;
        grant_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDW'(i);
                grant_op  = req_op[3*i +: 3];
                grant_a   = req_a[WIDTH*i +: WIDTH];
                grant_b   = req_b[WIDTH*i +: WIDTH];
            end
        end
        // Grants are only offered in IDLE and never while reset is asserted.
        req_ready = (rst_n && state_q == S_IDLE) ? grant : '0;
    end

    // Sequencer next-state: accept in IDLE, evaluate in EXEC, hold in RESP.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        op_count_d = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (|req_ready) begin
                    op_d     = grant_op;
                    a_d      = grant_a;
                    b_d      = grant_b;
                    id_d     = grant_idx;
                    rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d = gate_eval(op_q, a_q, b_q);
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    op_count_d = (op_count_q == 16'hFFFF) ? op_count_q : op_count_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            op_count_q <= op_count_d;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != S_IDLE);
    assign op_count  = op_count_q;

endmodule
